// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the load/store stage: opcodes, access
// encodings and the memory-stage state type.
package pipe_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // funct3[1:0] carries the access size; anything not byte/half is a word.
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic result;
    case (funct3[1:0])
      SIZE_B:  result = 1'b0;
      SIZE_H:  result = offset[0];
      default: result = (offset != 2'b00);
    endcase
    return result;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half/word lane out of a load response and
// sign- or zero-extends it to a full register value.
module load_align
  import pipe_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] value
);

  logic [31:0] shifted;

  // funct3[2] set means the unsigned variants (LBU/LHU).
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    value   = rdata;
    case (funct3[1:0])
      SIZE_B:  value = funct3[2] ? {24'b0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_H:  value = funct3[2] ? {16'b0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I load/store stage: runs req/gnt/rvalid data-bus transactions for
// loads and stores and passes all other instructions through in one cycle.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input  logic            req,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [6:0]      opcode_in,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] result_in,
  input  logic [XLEN-1:0] rs2_value_in,
  input  logic [4:0]      rd_in,
  input  logic            rd_write_in,
  output logic            stall_out,
  output logic            data_req_out,
  output logic [XLEN-1:0] data_addr_out,
  output logic            data_we_out,
  output logic [BE_W-1:0] data_be_out,
  output logic [XLEN-1:0] data_wdata_out,
  input  logic            data_gnt_in,
  input  logic            data_rvalid_in,
  input  logic [XLEN-1:0] data_rdata_in,
  output logic            valid_out,
  output logic [4:0]      rd_out,
  output logic            rd_write_out,
  output logic [XLEN-1:0] rd_value_out,
  output logic            misaligned_out
);

  mem_state_t  state;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_offset;
  logic [4:0]  lat_rd;
  logic        lat_rd_write;

  logic        is_load;
  logic        is_store;
  logic        misaligned;
  logic [1:0]  offset;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] load_value;

  assign offset     = result_in[1:0];
  assign is_load    = (opcode_in == OP_LOAD);
  assign is_store   = (opcode_in == OP_STORE);
  assign misaligned = is_misaligned(funct3_in, offset);
  assign stall_out  = (state != IDLE);

  // Store lanes: replicate narrow data across the word so the bus can pick
  // whichever lane the byte enables select.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = rs2_value_in;
    if (is_store) begin
      case (funct3_in[1:0])
        SIZE_B: begin
          be_next    = 4'b0001 << offset;
          wdata_next = {4{rs2_value_in[7:0]}};
        end
        SIZE_H: begin
          be_next    = 4'b0011 << offset;
          wdata_next = {2{rs2_value_in[15:0]}};
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = rs2_value_in;
        end
      endcase
    end
  end

  load_align u_load_align (
    .funct3 (lat_funct3),
    .offset (lat_offset),
    .rdata  (data_rdata_in),
    .value  (load_value)
  );

  // Pulses (valid/misaligned/rd_write) default low each cycle; rd_out and
  // rd_value_out hold until the next completing instruction.
  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      lat_funct3     <= 3'b0;
      lat_offset     <= 2'b0;
      lat_rd         <= 5'b0;
      lat_rd_write   <= 1'b0;
      data_req_out   <= 1'b0;
      data_addr_out  <= '0;
      data_we_out    <= 1'b0;
      data_be_out    <= '0;
      data_wdata_out <= '0;
      valid_out      <= 1'b0;
      rd_out         <= 5'b0;
      rd_write_out   <= 1'b0;
      rd_value_out   <= '0;
      misaligned_out <= 1'b0;
    end else begin
      valid_out      <= 1'b0;
      rd_write_out   <= 1'b0;
      misaligned_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            if (!is_load && !is_store) begin
              valid_out    <= 1'b1;
              rd_out       <= rd_in;
              rd_value_out <= result_in;
              rd_write_out <= rd_write_in;
            end else if (misaligned) begin
              valid_out      <= 1'b1;
              misaligned_out <= 1'b1;
              rd_out         <= rd_in;
            end else begin
              lat_funct3     <= funct3_in;
              lat_offset     <= offset;
              lat_rd         <= rd_in;
              lat_rd_write   <= rd_write_in;
              data_req_out   <= 1'b1;
              data_addr_out  <= {result_in[XLEN-1:2], 2'b00};
              data_we_out    <= is_store;
              data_be_out    <= be_next;
              data_wdata_out <= wdata_next;
              state          <= REQ;
            end
          end
        end
        REQ: begin
          if (data_gnt_in) begin
            data_req_out <= 1'b0;
            if (data_we_out) begin
              valid_out <= 1'b1;
              rd_out    <= lat_rd;
              state     <= IDLE;
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (data_rvalid_in) begin
            valid_out    <= 1'b1;
            rd_out       <= lat_rd;
            rd_write_out <= lat_rd_write;
            rd_value_out <= load_value;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against a byte-level model of
// RV32I load/store semantics.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [6:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic [31:0] result_in;
  logic [31:0] rs2_value_in;
  logic [4:0]  rd_in;
  logic        rd_write_in;
  logic        stall_out;
  logic        data_req_out;
  logic [31:0] data_addr_out;
  logic        data_we_out;
  logic [3:0]  data_be_out;
  logic [31:0] data_wdata_out;
  logic        data_gnt_in;
  logic        data_rvalid_in;
  logic [31:0] data_rdata_in;
  logic        valid_out;
  logic [4:0]  rd_out;
  logic        rd_write_out;
  logic [31:0] rd_value_out;
  logic        misaligned_out;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_ADDI  = 7'b0010011;
  localparam logic [6:0] OPC_ADD   = 7'b0110011;

  mem_stage dut (
    .req            (clk),
    .reset          (rst_n),
    .valid_in       (valid_in),
    .opcode_in      (opcode_in),
    .funct3_in      (funct3_in),
    .result_in      (result_in),
    .rs2_value_in   (rs2_value_in),
    .rd_in          (rd_in),
    .rd_write_in    (rd_write_in),
    .stall_out      (stall_out),
    .data_req_out   (data_req_out),
    .data_addr_out  (data_addr_out),
    .data_we_out    (data_we_out),
    .data_be_out    (data_be_out),
    .data_wdata_out (data_wdata_out),
    .data_gnt_in    (data_gnt_in),
    .data_rvalid_in (data_rvalid_in),
    .data_rdata_in  (data_rdata_in),
    .valid_out      (valid_out),
    .rd_out         (rd_out),
    .rd_write_out   (rd_write_out),
    .rd_value_out   (rd_value_out),
    .misaligned_out (misaligned_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access width in bytes from funct3 (unknown codes are words).
  function automatic int access_bytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int n;
    logic [63:0] mask;
    logic [31:0] v;
    n = access_bytes(f3);
    if (n == 4) return rdata;
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = (rdata >> (8 * (addr % 4))) & mask[31:0];
    if ((f3 == 3'b000 || f3 == 3'b001) && v[8*n-1]) v = v | ~mask[31:0];
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic is_store, input logic [2:0] f3,
                                          input logic [31:0] addr);
    int n;
    n = access_bytes(f3);
    if (!is_store || n == 4) return 4'hF;
    return 4'(((1 << n) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (access_bytes(f3))
      1:       return {24'b0, rs2[7:0]} * 32'h01010101;
      2:       return {16'b0, rs2[15:0]} * 32'h00010001;
      default: return rs2;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".stall"},  32'(stall_out), 0);
    check({tag, ".req"},    32'(data_req_out), 0);
    check({tag, ".addr"},   data_addr_out, 0);
    check({tag, ".we"},     32'(data_we_out), 0);
    check({tag, ".be"},     32'(data_be_out), 0);
    check({tag, ".wdata"},  data_wdata_out, 0);
    check({tag, ".valid"},  32'(valid_out), 0);
    check({tag, ".rd"},     32'(rd_out), 0);
    check({tag, ".rdw"},    32'(rd_write_out), 0);
    check({tag, ".value"},  rd_value_out, 0);
    check({tag, ".mis"},    32'(misaligned_out), 0);
  endtask

  // One instruction end to end, plus an idle cycle afterwards.
  task automatic run_txn(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                         input logic rdw, input int gnt_delay, input int rv_delay,
                         input logic [31:0] rdata);
    logic is_ld, is_st, mis;
    is_ld = (opc == OPC_LOAD);
    is_st = (opc == OPC_STORE);
    mis   = (is_ld || is_st) && ((addr % access_bytes(f3)) != 0);
    valid_in = 1'b1; opcode_in = opc; funct3_in = f3; result_in = addr;
    rs2_value_in = rs2; rd_in = rd; rd_write_in = rdw;
    tick();
    valid_in = 1'b0;
    if (!is_ld && !is_st) begin
      check({tag, ".pass.valid"}, 32'(valid_out), 1);
      check({tag, ".pass.rd"},    32'(rd_out), 32'(rd));
      check({tag, ".pass.value"}, rd_value_out, addr);
      check({tag, ".pass.rdw"},   32'(rd_write_out), 32'(rdw));
      check({tag, ".pass.req"},   32'(data_req_out), 0);
      check({tag, ".pass.stall"}, 32'(stall_out), 0);
    end else if (mis) begin
      check({tag, ".mis.flag"},  32'(misaligned_out), 1);
      check({tag, ".mis.valid"}, 32'(valid_out), 1);
      check({tag, ".mis.rdw"},   32'(rd_write_out), 0);
      check({tag, ".mis.req"},   32'(data_req_out), 0);
      check({tag, ".mis.stall"}, 32'(stall_out), 0);
      tick();
      check({tag, ".mis.pulse"}, 32'(misaligned_out), 0);
      check({tag, ".mis.req2"},  32'(data_req_out), 0);
    end else begin
      for (int i = 0; i <= gnt_delay; i++) begin
        if (i > 0) tick();
        check({tag, ".req"},   32'(data_req_out), 1);
        check({tag, ".addr"},  data_addr_out, addr & 32'hFFFF_FFFC);
        check({tag, ".we"},    32'(data_we_out), 32'(is_st));
        check({tag, ".be"},    32'(data_be_out), 32'(model_be(is_st, f3, addr)));
        if (is_st) check({tag, ".wdata"}, data_wdata_out, model_wdata(f3, rs2));
        check({tag, ".wait.valid"}, 32'(valid_out), 0);
        check({tag, ".stall"}, 32'(stall_out), 1);
      end
      data_gnt_in = 1'b1;
      tick();
      data_gnt_in = 1'b0;
      check({tag, ".gnt.req"}, 32'(data_req_out), 0);
      if (is_st) begin
        check({tag, ".st.valid"}, 32'(valid_out), 1);
        check({tag, ".st.rdw"},   32'(rd_write_out), 0);
        check({tag, ".st.stall"}, 32'(stall_out), 0);
      end else begin
        check({tag, ".ld.wait"},  32'(valid_out), 0);
        for (int i = 0; i < rv_delay; i++) begin
          data_rdata_in = $urandom;
          tick();
          check({tag, ".ld.hold"}, 32'(valid_out), 0);
          check({tag, ".ld.stall"}, 32'(stall_out), 1);
        end
        data_rdata_in = rdata; data_rvalid_in = 1'b1;
        tick();
        data_rvalid_in = 1'b0;
        check({tag, ".ld.valid"}, 32'(valid_out), 1);
        check({tag, ".ld.rd"},    32'(rd_out), 32'(rd));
        check({tag, ".ld.rdw"},   32'(rd_write_out), 32'(rdw));
        check({tag, ".ld.value"}, rd_value_out, model_load(f3, addr, rdata));
        check({tag, ".ld.stall"}, 32'(stall_out), 0);
      end
    end
    // Stray bus responses while idle must be ignored.
    data_gnt_in = 1'b1; data_rvalid_in = 1'b1;
    tick();
    data_gnt_in = 1'b0; data_rvalid_in = 1'b0;
    check({tag, ".idle.valid"}, 32'(valid_out), 0);
    check({tag, ".idle.rdw"},   32'(rd_write_out), 0);
    check({tag, ".idle.req"},   32'(data_req_out), 0);
  endtask

  initial begin
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [2:0]  ld_codes [6];
    logic [2:0]  st_codes [4];
    ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    st_codes = '{3'b000, 3'b001, 3'b010, 3'b111};

    rst_n = 1'b0; valid_in = 1'b0; opcode_in = '0; funct3_in = '0; result_in = '0;
    rs2_value_in = '0; rd_in = '0; rd_write_in = 1'b0; data_gnt_in = 1'b0;
    data_rvalid_in = 1'b0; data_rdata_in = '0;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_txn("addi", OPC_ADDI, 3'b000, 32'h5, 32'h0, 5'd1, 1'b1, 0, 0, 32'h0);
    run_txn("sw",   OPC_STORE, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 1, 0, 32'h0);
    run_txn("sb",   OPC_STORE, 3'b000, 32'h103, 32'h000000AB, 5'd0, 1'b0, 0, 0, 32'h0);
    run_txn("lb",   OPC_LOAD,  3'b000, 32'h102, 32'h0, 5'd7, 1'b1, 0, 1, 32'h0080FF00);
    run_txn("lbu",  OPC_LOAD,  3'b100, 32'h102, 32'h0, 5'd8, 1'b1, 2, 0, 32'h0080FF00);
    run_txn("lh_mis", OPC_LOAD, 3'b001, 32'h101, 32'h0, 5'd9, 1'b1, 0, 0, 32'h0);

    // Reset while waiting for the load response, then a late rvalid.
    valid_in = 1'b1; opcode_in = OPC_LOAD; funct3_in = 3'b010; result_in = 32'h200;
    rd_in = 5'd3; rd_write_in = 1'b1;
    tick();
    valid_in = 1'b0;
    data_gnt_in = 1'b1;
    tick();
    data_gnt_in = 1'b0;
    check("abort.inresp", 32'(stall_out), 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    tick();
    rst_n = 1'b1;
    data_rvalid_in = 1'b1; data_rdata_in = 32'h12345678;
    tick();
    data_rvalid_in = 1'b0;
    check("late_rvalid.valid", 32'(valid_out), 0);
    check("late_rvalid.value", rd_value_out, 0);
    check("late_rvalid.stall", 32'(stall_out), 0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: begin opc = ($urandom_range(0, 1) == 0) ? OPC_ADDI : OPC_ADD; f3 = 3'($urandom); end
        1: begin opc = OPC_LOAD;  f3 = ld_codes[$urandom_range(0, 5)]; end
        default: begin opc = OPC_STORE; f3 = st_codes[$urandom_range(0, 3)]; end
      endcase
      addr = $urandom;
      run_txn("rand", opc, f3, addr, $urandom, 5'($urandom), 1'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
